// File: rtl/ws2812_pkg.sv
// Shared definitions for the WS2812B frame sequencer and the downstream bitGenerator.
package ws2812_pkg;

  localparam int PIXEL_W = 24;

  localparam logic [1:0] GEN_RET  = 2'b00;
  localparam logic [1:0] GEN_ZERO = 2'b10;
  localparam logic [1:0] GEN_ONE  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_SHIFT = 3'd2,
    ST_RET   = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_t;

  // Per-channel right shift of a GRB pixel; each channel dims independently.
  function automatic logic [PIXEL_W-1:0] scale_pixel(input logic [PIXEL_W-1:0] px,
                                                     input logic [2:0]         shamt);
    scale_pixel = {px[23:16] >> shamt, px[15:8] >> shamt, px[7:0] >> shamt};
  endfunction

endpackage

// File: rtl/ws2812_pixel_buffer.sv
// One-entry prefetch buffer between the pixel source and the serializer.
// With WS2812_BRIGHTNESS_EN defined, pixels are dimmed as they are captured.
module ws2812_pixel_buffer
  import ws2812_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
`ifdef WS2812_BRIGHTNESS_EN
  input  logic               cfg_load,
  input  logic [2:0]         bright_shift,
`endif
  input  logic               allow,
  input  logic               pix_valid,
  input  logic [PIXEL_W-1:0] pix_data,
  input  logic               take,
  output logic               pix_ready,
  output logic               accept,
  output logic [PIXEL_W-1:0] nb,
  output logic               nb_v
);

  logic [PIXEL_W-1:0] nb_d, nb_q;
  logic               nb_v_d, nb_v_q;
  logic [PIXEL_W-1:0] pix_in_s;

`ifdef WS2812_BRIGHTNESS_EN
  logic [2:0] shamt_d, shamt_q;

  // Brightness is latched once per frame so a frame never mixes levels.
  always_comb begin
    shamt_d = shamt_q;
    if (cfg_load) begin
      shamt_d = bright_shift;
    end else begin
      shamt_d = shamt_q;
    end
  end

  assign pix_in_s = scale_pixel(pix_data, shamt_q);
`else
  assign pix_in_s = pix_data;
`endif

  assign pix_ready = allow && !nb_v_q;
  assign accept    = pix_valid && pix_ready;
  assign nb        = nb_q;
  assign nb_v      = nb_v_q;

  // A new pixel takes priority over the consumer draining the slot.
  always_comb begin
    nb_d   = nb_q;
    nb_v_d = nb_v_q;
    if (accept) begin
      nb_d   = pix_in_s;
      nb_v_d = 1'b1;
    end else if (take) begin
      nb_v_d = 1'b0;
    end else begin
      nb_v_d = nb_v_q;
    end
  end

  // Buffer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      nb_q   <= {PIXEL_W{1'b0}};
      nb_v_q <= 1'b0;
`ifdef WS2812_BRIGHTNESS_EN
      shamt_q <= 3'd0;
`endif
    end else begin
      nb_q   <= nb_d;
      nb_v_q <= nb_v_d;
`ifdef WS2812_BRIGHTNESS_EN
      shamt_q <= shamt_d;
`endif
    end
  end

endmodule

// File: rtl/ws2812_frame_sequencer.sv
// Serializes NUM_LEDS GRB pixels into bitGenerator commands, then issues RET.
// Optional feature macro: WS2812_BRIGHTNESS_EN (adds bright_shift input).
module ws2812_frame_sequencer
  import ws2812_pkg::*;
#(
  parameter int NUM_LEDS = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
`ifdef WS2812_BRIGHTNESS_EN
  input  logic [2:0]         bright_shift,
`endif
  input  logic               pix_valid,
  input  logic [PIXEL_W-1:0] pix_data,
  output logic               pix_ready,
  output logic [1:0]         genMode,
  output logic               doGen,
  input  logic               genDone,
  input  logic               retDone,
  output logic               busy,
  output logic               frame_done,
  output logic               underrun
);

  localparam int              CNT_W    = $clog2(NUM_LEDS + 1);
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(NUM_LEDS - 1);
  localparam logic [CNT_W-1:0] MAX_PIX  = CNT_W'(NUM_LEDS);
  localparam logic [4:0]       LAST_BIT = 5'd23;

  seq_state_t         state_d, state_q;
  logic [PIXEL_W-1:0] sh_d, sh_q;
  logic [4:0]         bit_d, bit_q;
  logic [CNT_W-1:0]   pix_d, pix_q;
  logic [CNT_W-1:0]   acc_d, acc_q;
  logic               underrun_d, underrun_q;

  logic               allow_s;
  logic               accept_s;
  logic               take_s;
  logic [PIXEL_W-1:0] nb_s;
  logic               nb_v_s;

  assign allow_s = (state_q != ST_IDLE) && (acc_q < MAX_PIX);

  ws2812_pixel_buffer u_pixel_buffer (
    .clk          (clk),
    .reset        (reset),
`ifdef WS2812_BRIGHTNESS_EN
    .cfg_load     ((state_q == ST_IDLE) && start),
    .bright_shift (bright_shift),
`endif
    .allow        (allow_s),
    .pix_valid    (pix_valid),
    .pix_data     (pix_data),
    .take         (take_s),
    .pix_ready    (pix_ready),
    .accept       (accept_s),
    .nb           (nb_s),
    .nb_v         (nb_v_s)
  );

  // Next-state logic; a waiting pixel is loaded on the same edge as bit 23's genDone.
  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    bit_d      = bit_q;
    pix_d      = pix_q;
    acc_d      = acc_q;
    underrun_d = underrun_q;
    take_s     = 1'b0;
    if (accept_s) begin
      acc_d = acc_q + CNT_W'(1);
    end else begin
      acc_d = acc_q;
    end
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          underrun_d = 1'b0;
          bit_d      = 5'd0;
          pix_d      = {CNT_W{1'b0}};
          acc_d      = {CNT_W{1'b0}};
          state_d    = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (nb_v_s) begin
          sh_d    = nb_s;
          take_s  = 1'b1;
          bit_d   = 5'd0;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_SHIFT: begin
        if (!genDone) begin
          state_d = ST_SHIFT;
        end else if (bit_q != LAST_BIT) begin
          sh_d  = {sh_q[PIXEL_W-2:0], 1'b0};
          bit_d = bit_q + 5'd1;
        end else begin
          bit_d = 5'd0;
          pix_d = pix_q + CNT_W'(1);
          if (pix_q == LAST_PIX) begin
            state_d = ST_RET;
          end else if (nb_v_s) begin
            sh_d   = nb_s;
            take_s = 1'b1;
          end else begin
            underrun_d = 1'b1;
            state_d    = ST_FETCH;
          end
        end
      end
      ST_RET: begin
        if (retDone) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RET;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      sh_q       <= {PIXEL_W{1'b0}};
      bit_q      <= 5'd0;
      pix_q      <= {CNT_W{1'b0}};
      acc_q      <= {CNT_W{1'b0}};
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      bit_q      <= bit_d;
      pix_q      <= pix_d;
      acc_q      <= acc_d;
      underrun_q <= underrun_d;
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign doGen      = (state_q == ST_SHIFT) || (state_q == ST_RET);
  assign genMode    = (state_q == ST_SHIFT) ? (sh_q[PIXEL_W-1] ? GEN_ONE : GEN_ZERO) : GEN_RET;
  assign frame_done = (state_q == ST_DONE);
  assign underrun   = underrun_q;

endmodule
